// File: rtl/fc_pkg.sv
// Shared widths, state encoding and layer constants for the fully connected
// layers (full_connect1 produces the activation word full_connect2 consumes).
package fc_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_W     = 1024;
  localparam int WORD_BYTES = WORD_W / BYTE_W;
  localparam int MA_W       = 15;   // MultAdder dot-product width
  localparam int ACC_W      = 19;   // holds seven sign-extended MultAdder results

  // Layer constants shared between the two fully connected stages
  localparam int FC1_NEURONS    = 128;
  localparam int FC1_IN_CHUNKS  = 7;
  localparam int FC1_LAST_VALID = 16;
  localparam int FC1_SHIFT      = 7;
  localparam int FC1_OUT_ADDR   = 8;
  localparam int FC2_IN_ADDR    = FC1_OUT_ADDR;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CALC,
    S_ACT,
    S_WRITE,
    S_DONE
  } fc_state_e;

  // Byte-lane mask keeping the lowest valid_bytes bytes of a word
  function automatic logic [WORD_W-1:0] byte_mask(input int valid_bytes);
    logic [WORD_W-1:0] m;
    m = '0;
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (b < valid_bytes) m[b*BYTE_W +: BYTE_W] = '1;
    end
    return m;
  endfunction

endpackage

// File: rtl/act_quant.sv
// act_quant: turns a neuron accumulator into its int8 activation.
// Arithmetic right shift by SHIFT, then saturation to [-128,127].
// Build option FC1_RELU_EN: negative shifted values clamp to 0, so the
// activation range becomes [0,127].
module act_quant
  import fc_pkg::*;
#(
  parameter int SHIFT = 7
) (
  input  logic signed [ACC_W-1:0]  i_acc,
  output logic        [BYTE_W-1:0] o_q
);

  localparam logic signed [ACC_W-1:0] S8_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] S8_MIN = ACC_W'(-128);

  function automatic logic [BYTE_W-1:0] sat_s8(input logic signed [ACC_W-1:0] v);
    if (v > S8_MAX) return 8'h7F;
    if (v < S8_MIN) return 8'h80;
    return v[BYTE_W-1:0];
  endfunction

  logic signed [ACC_W-1:0] w_shift;

  assign w_shift = i_acc >>> SHIFT;

  // Scale down, optionally rectify, then clamp into a signed byte
  always_comb begin
    o_q = sat_s8(w_shift);
`ifdef FC1_RELU_EN
    if (w_shift[ACC_W-1]) o_q = '0;
`else
    o_q = sat_s8(w_shift);
`endif
  end

endmodule

// File: rtl/full_connect1.sv
// full_connect1: first fully connected layer of the digit classifier.
// For each of NEURONS hidden neurons, IN_CHUNKS weight words (ROM) and image
// words (RAM) are fed pairwise through the external MultAdder; the partial
// dot products are accumulated, quantized to int8 and packed into one word
// written to RAM at OUT_ADDR. Build option FC1_RELU_EN selects ReLU before
// saturation (see act_quant).
module full_connect1
  import fc_pkg::*;
#(
  parameter int NEURONS    = FC1_NEURONS,
  parameter int IN_CHUNKS  = FC1_IN_CHUNKS,
  parameter int LAST_VALID = FC1_LAST_VALID,
  parameter int SHIFT      = FC1_SHIFT,
  parameter int W_BASE     = 0,
  parameter int IN_BASE    = 0,
  parameter int OUT_ADDR   = FC1_OUT_ADDR
) (
  input  logic              clk,
  input  logic              iRst_n,
  input  logic              ena,
  input  logic [WORD_W-1:0] data_from_rom,
  input  logic [WORD_W-1:0] data_from_ram,
  input  logic [MA_W-1:0]   data_from_MultAdder,
  input  logic              overflow_from_MultAdder,
  output logic              overflow,
  output logic              done,
  output logic [31:0]       addr_to_rom,
  output logic [31:0]       addr_to_ram,
  output logic              wr_en_to_ram,
  output logic [WORD_W-1:0] opr1_to_MultAdder,
  output logic [WORD_W-1:0] opr2_to_MultAdder,
  output logic [WORD_W-1:0] data_to_ram
);

  localparam int N_W = (NEURONS > 1) ? $clog2(NEURONS) : 1;
  localparam int C_W = (IN_CHUNKS > 1) ? $clog2(IN_CHUNKS) : 1;
  localparam logic [N_W-1:0]    N_LAST    = N_W'(NEURONS - 1);
  localparam logic [C_W-1:0]    C_LAST    = C_W'(IN_CHUNKS - 1);
  // The image is not a whole number of words: the tail of the last chunk
  // holds unrelated RAM contents and must not reach the MultAdder.
  localparam logic [WORD_W-1:0] LAST_MASK = byte_mask(LAST_VALID);

  fc_state_e               r_state;
  fc_state_e               w_next;
  logic [N_W-1:0]          r_n;
  logic [C_W-1:0]          r_c;
  logic signed [ACC_W-1:0] r_acc;
  logic [WORD_W-1:0]       r_result;
  logic                    r_overflow;

  logic signed [MA_W-1:0]  w_mult;
  logic signed [ACC_W-1:0] w_mult_ext;
  logic [BYTE_W-1:0]       w_q;
  logic [31:0]             w_rom_addr;
  logic [31:0]             w_ram_addr;
  logic                    w_last_chunk;
  logic                    w_last_neuron;

  assign w_mult        = data_from_MultAdder;
  assign w_mult_ext    = {{(ACC_W-MA_W){w_mult[MA_W-1]}}, w_mult};
  assign w_last_chunk  = (r_c == C_LAST);
  assign w_last_neuron = (r_n == N_LAST);
  assign w_rom_addr    = 32'(W_BASE) + 32'(r_n) * 32'(IN_CHUNKS) + 32'(r_c);
  assign w_ram_addr    = 32'(IN_BASE) + 32'(r_c);
  assign overflow      = r_overflow;

  act_quant #(
    .SHIFT (SHIFT)
  ) u_act_quant (
    .i_acc (r_acc),
    .o_q   (w_q)
  );

  // State register; reset wins over everything else
  always_ff @(posedge clk) begin
    if (!iRst_n) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state: dropping ena aborts any active state back to IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (ena) w_next = S_FETCH;
      S_FETCH: w_next = ena ? S_CALC : S_IDLE;
      S_CALC: begin
        if (!ena)              w_next = S_IDLE;
        else if (w_last_chunk) w_next = S_ACT;
        else                   w_next = S_FETCH;
      end
      S_ACT: begin
        if (!ena)               w_next = S_IDLE;
        else if (w_last_neuron) w_next = S_WRITE;
        else                    w_next = S_FETCH;
      end
      S_WRITE: w_next = ena ? S_DONE : S_IDLE;
      S_DONE:  if (!ena) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Loop counters, accumulator, sticky overflow and packed result register
  always_ff @(posedge clk) begin
    if (!iRst_n) begin
      r_n        <= '0;
      r_c        <= '0;
      r_acc      <= '0;
      r_result   <= '0;
      r_overflow <= 1'b0;
    end else if (ena) begin
      case (r_state)
        S_IDLE: begin
          r_n        <= '0;
          r_c        <= '0;
          r_acc      <= '0;
          r_overflow <= 1'b0;
        end
        S_CALC: begin
          r_acc      <= r_acc + w_mult_ext;
          r_overflow <= r_overflow | overflow_from_MultAdder;
          if (!w_last_chunk) r_c <= r_c + 1'b1;
        end
        S_ACT: begin
          r_result[{r_n, 3'b000} +: BYTE_W] <= w_q;
          r_acc <= '0;
          r_c   <= '0;
          if (!w_last_neuron) r_n <= r_n + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Bus outputs decoded from state; everything idles at zero
  always_comb begin
    addr_to_rom       = '0;
    addr_to_ram       = '0;
    wr_en_to_ram      = 1'b0;
    opr1_to_MultAdder = '0;
    opr2_to_MultAdder = '0;
    data_to_ram       = '0;
    done              = 1'b0;
    case (r_state)
      S_FETCH: begin
        addr_to_rom = w_rom_addr;
        addr_to_ram = w_ram_addr;
      end
      S_CALC: begin
        opr1_to_MultAdder = data_from_rom;
        opr2_to_MultAdder = w_last_chunk ? (data_from_ram & LAST_MASK) : data_from_ram;
      end
      S_WRITE: begin
        addr_to_ram  = 32'(OUT_ADDR);
        wr_en_to_ram = ena;
        data_to_ram  = r_result;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_full_connect1.sv
// Testbench for full_connect1: ROM/RAM/MultAdder models, a dot-product
// reference model over the 784-byte image, and a scoreboard monitor.
module tb_full_connect1;

  localparam int NN     = 128;
  localparam int NCH    = 7;
  localparam int NPIX   = 784;
  localparam int LAT    = NN * (2 * NCH + 1) + 2;  // edges counted from the start edge, inclusive
  localparam int OUTA   = 8;

  logic          clk = 1'b0;
  logic          iRst_n, ena;
  logic [1023:0] data_from_rom, data_from_ram;
  logic [14:0]   data_from_MultAdder;
  logic          overflow_from_MultAdder;
  logic          overflow, done, wr_en_to_ram;
  logic [31:0]   addr_to_rom, addr_to_ram;
  logic [1023:0] opr1_to_MultAdder, opr2_to_MultAdder, data_to_ram;

  always #5 clk = ~clk;

  full_connect1 dut (
    .clk                     (clk),
    .iRst_n                  (iRst_n),
    .ena                     (ena),
    .data_from_rom           (data_from_rom),
    .data_from_ram           (data_from_ram),
    .data_from_MultAdder     (data_from_MultAdder),
    .overflow_from_MultAdder (overflow_from_MultAdder),
    .overflow                (overflow),
    .done                    (done),
    .addr_to_rom             (addr_to_rom),
    .addr_to_ram             (addr_to_ram),
    .wr_en_to_ram            (wr_en_to_ram),
    .opr1_to_MultAdder       (opr1_to_MultAdder),
    .opr2_to_MultAdder       (opr2_to_MultAdder),
    .data_to_ram             (data_to_ram)
  );

  // ---------------- memory and MultAdder models ----------------
  logic [1023:0] rom_mem [NN*NCH];
  logic [1023:0] ram_mem [16];

  always @(posedge clk) begin
    data_from_rom <= (addr_to_rom < NN*NCH) ? rom_mem[addr_to_rom[9:0]] : '0;
    data_from_ram <= (addr_to_ram < 16) ? ram_mem[addr_to_ram[3:0]] : '0;
  end

  bit          const_mode;
  logic [14:0] const_val;
  bit          inj;
  int          ma_sum;

  function automatic int dot(input logic [1023:0] a, input logic [1023:0] x);
    int s;
    s = 0;
    for (int b = 0; b < 128; b++)
      s += int'($signed(a[b*8 +: 8])) * int'($signed(x[b*8 +: 8]));
    return s;
  endfunction

  always_comb begin
    ma_sum = dot(opr1_to_MultAdder, opr2_to_MultAdder);
    data_from_MultAdder = const_mode ? const_val : ma_sum[14:0];
    overflow_from_MultAdder = inj | (!const_mode && (ma_sum > 16383 || ma_sum < -16384));
  end

  // ---------------- reference model ----------------
  byte           img [NPIX];
  byte           wt  [NN][NPIX];
  logic [1023:0] exp_word;

  function automatic logic [7:0] quant(input int acc);
    int s;
    s = acc >>> 7;
`ifdef FC1_RELU_EN
    if (s < 0) s = 0;
`endif
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    return 8'(s);
  endfunction

  task automatic setup_const(input logic [14:0] v);
    int acc;
    for (int i = 0; i < NN*NCH; i++) rom_mem[i] = {128{8'h01}};
    for (int i = 0; i < 16; i++)     ram_mem[i] = {128{8'h02}};
    const_mode = 1'b1;
    const_val  = v;
    acc = NCH * int'($signed(v));
    for (int n = 0; n < NN; n++) exp_word[n*8 +: 8] = quant(acc);
  endtask

  task automatic setup_random();
    int acc, idx;
    const_mode = 1'b0;
    for (int k = 0; k < NPIX; k++) img[k] = byte'($urandom_range(0, 10));
    for (int n = 0; n < NN; n++)
      for (int k = 0; k < NPIX; k++)
        case (n % 3)
          0:       wt[n][k] = byte'(int'($urandom_range(0, 20)) - 10);
          1:       wt[n][k] = byte'($urandom_range(0, 10));
          default: wt[n][k] = byte'(-int'($urandom_range(0, 10)));
        endcase
    for (int n = 0; n < NN; n++)
      for (int c = 0; c < NCH; c++)
        for (int b = 0; b < 128; b++) begin
          idx = c*128 + b;
          rom_mem[n*NCH + c][b*8 +: 8] = (idx < NPIX) ? wt[n][idx] : 8'($urandom_range(1, 100));
        end
    for (int c = 0; c < 16; c++)
      for (int b = 0; b < 128; b++) begin
        idx = c*128 + b;
        if (c >= NCH)         ram_mem[c][b*8 +: 8] = 8'h00;
        else if (idx < NPIX)  ram_mem[c][b*8 +: 8] = img[idx];
        else                  ram_mem[c][b*8 +: 8] = 8'($urandom_range(1, 100));
      end
    for (int n = 0; n < NN; n++) begin
      acc = 0;
      for (int k = 0; k < NPIX; k++) acc += int'(wt[n][k]) * int'(img[k]);
      exp_word[n*8 +: 8] = quant(acc);
    end
  endtask

  // ---------------- checking helpers ----------------
  int total = 0;
  int bad   = 0;

  task automatic chki(input string nm, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic chkw(input string nm, input logic [1023:0] act, input logic [1023:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic chk_outputs_zero(input string nm);
    chki({nm, "_ctl"}, longint'({overflow, done, wr_en_to_ram}), 0);
    chki({nm, "_addr"}, longint'({addr_to_rom, addr_to_ram}), 0);
    chkw({nm, "_data"}, opr1_to_MultAdder | opr2_to_MultAdder | data_to_ram, '0);
  endtask

  // ---------------- scoreboard monitor ----------------
  typedef struct {
    logic [1023:0] data;
    bit            ovf;
  } exp_t;
  exp_t exp_q[$];

  int          rom_next, rom_bad, mask_cnt, mask_bad;
  logic [31:0] last_rom, last_ram;
  bit          pend, pend_ovf;

  initial begin
    exp_t e;
    pend = 0;
    forever begin
      @(negedge clk);
      if (iRst_n === 1'b1) begin
        if (opr1_to_MultAdder != '0) begin
          if (last_rom != 32'(rom_next)) rom_bad++;
          rom_next++;
          if (last_ram == NCH - 1) begin
            mask_cnt++;
            if (opr2_to_MultAdder[1023:128] != '0) mask_bad++;
          end
        end
        last_rom = addr_to_rom;
        last_ram = addr_to_ram;
        if (pend) begin
          chki("done_after_write", longint'(done), 1);
          chki("overflow_at_done", longint'(overflow), longint'(pend_ovf));
          chki("write_one_cycle", longint'(wr_en_to_ram), 0);
          pend = 0;
        end
        if (wr_en_to_ram === 1'b1) begin
          if (exp_q.size() == 0) begin
            chki("unexpected_write", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chki("write_addr", longint'(addr_to_ram), OUTA);
            chkw("write_data", data_to_ram, e.data);
            chki("rom_addr_count", rom_next, NN*NCH);
            chki("rom_addr_order_errors", rom_bad, 0);
            chki("last_chunk_count", mask_cnt, NN);
            chki("last_chunk_mask_errors", mask_bad, 0);
            pend     = 1;
            pend_ovf = e.ovf;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_tracking();
    rom_next = 0;
    rom_bad  = 0;
    mask_cnt = 0;
    mask_bad = 0;
  endtask

  task automatic inject_ovf();
    bit found;
    found = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (addr_to_rom == 32'(5*NCH + 3)) begin
        found = 1;
        break;
      end
    end
    chki("ovf_neuron5_reached", longint'(found), 1);
    if (found) begin
      @(posedge clk);
      #1;
      chki("ovf_before_pulse", longint'(overflow), 0);
      inj = 1'b1;
      @(posedge clk);
      #1;
      inj = 1'b0;
      chki("ovf_after_pulse", longint'(overflow), 1);
    end
  endtask

  // Complete run: expectation queued first, then ena raised in IDLE
  task automatic run_full(input bit do_inj);
    exp_t e;
    int   cnt;
    e.data = exp_word;
    e.ovf  = do_inj;
    exp_q.push_back(e);
    clear_tracking();
    ena = 1'b1;
    fork
      begin
        cnt = 0;
        for (int i = 0; i < LAT + 500; i++) begin
          @(posedge clk);
          #1;
          cnt++;
          if (done) break;
        end
        chki("done_latency", cnt, LAT);
      end
      begin
        if (do_inj) inject_ovf();
      end
    join
    @(negedge clk);
    @(posedge clk);
    #1;
    chki("done_held", longint'(done), 1);
    ena = 1'b0;
    @(posedge clk);
    #1;
    chki("done_cleared", longint'(done), 0);
  endtask

  // Run cut short by reset or by dropping ena; no write may follow
  task automatic run_abort(input bit use_rst, input int at);
    clear_tracking();
    ena = 1'b1;
    repeat (at) @(posedge clk);
    #1;
    if (use_rst) iRst_n = 1'b0;
    else         ena    = 1'b0;
    @(posedge clk);
    #1;
    chk_outputs_zero(use_rst ? "rst_abort" : "ena_abort");
    iRst_n = 1'b1;
    ena    = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk_outputs_zero(use_rst ? "rst_abort_idle" : "ena_abort_idle");
  endtask

  initial begin
    iRst_n     = 1'b0;
    ena        = 1'b0;
    inj        = 1'b0;
    const_mode = 1'b0;
    const_val  = '0;
    for (int i = 0; i < NN*NCH; i++) rom_mem[i] = '0;
    for (int i = 0; i < 16; i++)     ram_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    iRst_n = 1'b1;
    @(posedge clk);
    #1;

    setup_const(15'h0143);   // 7*323 = 2261 -> 17
    run_full(1'b0);
    setup_const(15'h7F00);   // 7*(-256) = -1792 -> -14
    run_full(1'b0);
    setup_const(15'h3FFF);   // 7*16383 = 114681 -> 895, saturates
    run_full(1'b0);

    setup_random();
    run_full(1'b1);
    setup_random();
    run_full(1'b0);

    setup_random();
    run_abort(1'b1, 500);
    run_full(1'b0);

    setup_random();
    run_abort(1'b0, 300);
    run_full(1'b0);

    repeat (5) @(posedge clk);
    #1;
    chki("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
